// File: rtl/wb_mux_pipe.sv
// Registered N:1 word selector with a valid/ready output stage, sticky bad-select flag and transfer counter.
// Build option: define WB_MUX_PIPE_SKID_EN to add a one-entry skid register and a registered in_ready.
module wb_mux_pipe #(
  parameter int WIDTH   = 16,
  parameter int NUM_SRC = 4,
  parameter int SEL_W   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_SRC*WIDTH-1:0] src,
  input  logic [SEL_W-1:0]         sel,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [SEL_W-1:0]         out_sel,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     sel_err,
  output logic [15:0]              xfer_cnt
);

  // Handshake: a word moves on any cycle where valid and ready are both high;
  // the producer keeps valid/data stable until then, ready never depends on valid.

  logic [WIDTH-1:0] mux_data;
  logic             sel_bad;
  logic [WIDTH-1:0] data_q;
  logic [SEL_W-1:0] sel_q;
  logic             valid_q;
  logic             err_q;
  logic [15:0]      xfer_cnt_q;
  logic             in_xfer;
  logic             out_xfer;

  // An out-of-range select matches no source and yields all-zero data.
  always_comb begin
    mux_data = '0;
    sel_bad  = 1'b1;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (sel == SEL_W'(i)) begin
        mux_data = src[i*WIDTH +: WIDTH];
        sel_bad  = 1'b0;
      end
    end
  end

  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = valid_q & out_ready;
  assign out_data  = data_q;
  assign out_sel   = sel_q;
  assign out_valid = valid_q;
  assign sel_err   = err_q;
  assign xfer_cnt  = xfer_cnt_q;

`ifdef WB_MUX_PIPE_SKID_EN
  logic             skid_full;
  logic [WIDTH-1:0] skid_data;
  logic [SEL_W-1:0] skid_sel;
  logic             out_load;

  assign in_ready = ~skid_full;
  assign out_load = ~valid_q | out_ready;

  // The skid word always drains ahead of new input, which preserves order.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      data_q    <= '0;
      sel_q     <= '0;
      skid_full <= 1'b0;
      skid_data <= '0;
      skid_sel  <= '0;
    end else if (out_load) begin
      if (skid_full) begin
        valid_q   <= 1'b1;
        data_q    <= skid_data;
        sel_q     <= skid_sel;
        skid_full <= 1'b0;
      end else if (in_xfer) begin
        valid_q <= 1'b1;
        data_q  <= mux_data;
        sel_q   <= sel;
      end else begin
        valid_q <= 1'b0;
      end
    end else if (in_xfer) begin
      skid_full <= 1'b1;
      skid_data <= mux_data;
      skid_sel  <= sel;
    end
  end
`else
  assign in_ready = ~valid_q | out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sel_q   <= '0;
    end else if (in_xfer) begin
      valid_q <= 1'b1;
      data_q  <= mux_data;
      sel_q   <= sel;
    end else if (out_xfer) begin
      valid_q <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q      <= 1'b0;
      xfer_cnt_q <= '0;
    end else begin
      if (in_xfer && sel_bad)
        err_q <= 1'b1;
      if (out_xfer && (xfer_cnt_q != 16'hFFFF))
        xfer_cnt_q <= xfer_cnt_q + 16'd1;
    end
  end

endmodule
